// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: shared FSM state type and framing constants
// for the single-master I2C initiator.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int START_QTRS = 2;
  localparam int STOP_QTRS  = 3;
  localparam int BYTE_SLOTS = 9;

  localparam logic [2:0] LAST_BIT = 3'(BYTE_SLOTS - 2);

endpackage

// File: rtl/scl_tick_gen.sv
// scl_tick_gen: SCL quarter-period counter; holds at zero while
// the bus clock is being stretched.
module scl_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || !run)
      cnt <= '0;
    else if (hold && cnt == '0)
      cnt <= cnt;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-master I2C initiator; one-byte writes and
// 1..4 byte reads, open-drain style SCL/SDA outputs.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wr_byte,
  input  logic [1:0] rd_len,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  state_t     state, state_d;
  logic [1:0] qtr, q_last;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt, len_q;
  logic [7:0] tx_sh, rx_sh, wr_q;
  logic       rw_q;
  logic       tick, accept, in_slot;
  logic       hold, q_end, sample, last_byte;

  assign accept    = start && !busy;
  assign in_slot   = state inside {ADDR, ADDR_ACK, WRITE,
                                   WRITE_ACK, READ, READ_ACK};
  assign hold      = in_slot && qtr == Q2 && !scl_in;
  assign sample    = tick && in_slot && qtr == Q2;
  assign last_byte = byte_cnt == len_q;

  scl_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .run  (busy),
    .hold (hold),
    .tick (tick)
  );

  always_comb begin
    q_last = Q3;
    unique case (state)
      START:   q_last = 2'(START_QTRS - 1);
      STOP:    q_last = 2'(STOP_QTRS - 1);
      default: q_last = Q3;
    endcase
  end

  assign q_end = tick && qtr == q_last;

  always_comb begin
    state_d = state;
    scl_out = 1'b1;
    sda_out = 1'b1;
    unique case (state)
      IDLE: if (accept) state_d = START;
      START: begin
        sda_out = (qtr != Q1);
        if (q_end) state_d = ADDR;
      end
      ADDR, WRITE: begin
        scl_out = qtr[1];
        sda_out = tx_sh[7];
        if (q_end && bit_cnt == LAST_BIT)
          state_d = (state == ADDR) ? ADDR_ACK : WRITE_ACK;
      end
      ADDR_ACK: begin
        scl_out = qtr[1];
        // ack_err was captured at the Q2 sample of this slot
        if (q_end)
          state_d = ack_err ? STOP : (rw_q ? READ : WRITE);
      end
      WRITE_ACK: begin
        scl_out = qtr[1];
        if (q_end) state_d = STOP;
      end
      READ: begin
        scl_out = qtr[1];
        if (q_end && bit_cnt == LAST_BIT) state_d = READ_ACK;
      end
      READ_ACK: begin
        scl_out = qtr[1];
        sda_out = last_byte;
        if (q_end) state_d = last_byte ? STOP : READ;
      end
      STOP: begin
        scl_out = (qtr != Q0);
        sda_out = (qtr == Q2);
        if (q_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      qtr      <= Q0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      wr_q     <= '0;
      rw_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_d;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        ack_err  <= 1'b0;
        qtr      <= Q0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        rw_q     <= rw;
        len_q    <= rd_len;
        wr_q     <= wr_byte;
        tx_sh    <= {addr, rw};
      end else if (tick) begin
        qtr <= q_end ? Q0 : qtr + 2'd1;
        if (sample) begin
          if ((state == ADDR_ACK || state == WRITE_ACK) && sda_in)
            ack_err <= 1'b1;
          if (state == READ) begin
            rx_sh <= {rx_sh[6:0], sda_in};
            if (bit_cnt == LAST_BIT) begin
              rd_data  <= {rx_sh[6:0], sda_in};
              rd_valid <= 1'b1;
            end
          end
        end
        if (q_end) begin
          // bit_cnt wraps 7 -> 0, ready for the next byte
          if (state inside {ADDR, WRITE, READ})
            bit_cnt <= bit_cnt + 3'd1;
          if (state inside {ADDR, WRITE})
            tx_sh <= {tx_sh[6:0], 1'b0};
          if (state == ADDR_ACK)
            tx_sh <= wr_q;
          if (state == READ_ACK)
            byte_cnt <= byte_cnt + 2'd1;
          if (state == STOP) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized transactions against a bus-level slave
// and a transaction-level reference for timing, bytes and ACKs.
module tb_i2c_master;

  localparam int D = 4;
  localparam int STRETCH = 50;
  localparam logic [6:0] SLV = 7'h2A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wr_byte = '0;
  logic [1:0] rd_len = '0;
  logic       scl_in, sda_in, scl_out, sda_out;
  logic       busy, done, ack_err, rd_valid;
  logic [7:0] rd_data;

  i2c_master #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wr_byte (wr_byte),
    .rd_len  (rd_len),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .scl_out (scl_out),
    .sda_out (sda_out),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_done = 0;
  always @(negedge clk) if (done) n_done++;

  // bus-level slave: wired-AND bus, acks SLV, serves sdata on reads
  logic       slave_sda = 1'b1;
  logic       slave_hold = 1'b0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       acked = 1'b0, mnack = 1'b0;
  int         rises = 0, starts = 0, stops = 0, hold_cnt = 0;
  int         stretch_slot = -1;
  logic       bus_bits [64];
  logic [7:0] sdata [4];

  assign sda_in = sda_out & slave_sda;
  assign scl_in = scl_out & ~slave_hold;

  always @(negedge clk) begin
    logic       s_scl, s_sda;
    logic [6:0] a;
    int         s, j;
    s_scl = scl_in;
    s_sda = sda_in;
    if (rst) begin
      slave_sda  = 1'b1;
      slave_hold = 1'b0;
      p_scl = 1'b1;
      p_sda = 1'b1;
      acked = 1'b0;
      mnack = 1'b0;
      rises = 0;
    end else begin
      if (s_scl && p_scl && p_sda && !s_sda) begin
        starts++;
        rises = 0;
        acked = 1'b0;
        mnack = 1'b0;
        slave_sda = 1'b1;
      end else if (s_scl && p_scl && !p_sda && s_sda) begin
        stops++;
        slave_sda = 1'b1;
      end else if (s_scl && !p_scl) begin
        if (rises < 64) bus_bits[rises] = s_sda;
        if (acked && bus_bits[7] && rises > 8 &&
            (rises - 9) % 9 == 8 && s_sda)
          mnack = 1'b1;
        rises++;
      end else if (!s_scl && p_scl) begin
        s = rises;
        slave_sda = 1'b1;
        if (s == 8) begin
          a = '0;
          for (int i = 0; i < 7; i++) a = {a[5:0], bus_bits[i]};
          acked = (a == SLV);
          slave_sda = !acked;
        end else if (acked && s > 8) begin
          j = (s - 9) % 9;
          if (bus_bits[7]) begin
            if (!mnack && j < 8)
              slave_sda = sdata[((s - 9) / 9) % 4][7 - j];
          end else if (s == 17) begin
            slave_sda = 1'b0;
          end
        end
        if (s == stretch_slot) begin
          slave_hold = 1'b1;
          hold_cnt = 0;
        end
      end
      if (slave_hold && scl_out) begin
        if (hold_cnt == STRETCH) slave_hold = 1'b0;
        else hold_cnt++;
      end
      p_scl = s_scl;
      p_sda = s_sda;
    end
  end

  function automatic logic [7:0] bus_byte(input int o);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], bus_bits[o + i]};
    return r;
  endfunction

  task automatic run_txn(input logic t_rw, input logic [6:0] t_addr,
                         input logic [7:0] t_wr, input logic [1:0] t_len,
                         input bit t_stretch, input bit t_spam);
    int unsigned c0;
    int          n, exp_cyc, slots, st0, sp0, d0;
    bit          nack, got_done;
    logic [7:0]  got[$];
    nack = (t_addr != SLV);
    n = int'(t_len) + 1;
    exp_cyc = (nack ? 41 : (t_rw ? 41 + 36 * n : 77)) * D + 1
            + (t_stretch ? STRETCH : 0);
    stretch_slot = t_stretch ? 3 : -1;
    st0 = starts;
    sp0 = stops;
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    rw = t_rw;
    addr = t_addr;
    wr_byte = t_wr;
    rd_len = t_len;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    rw = 1'($urandom);
    addr = 7'($urandom);
    wr_byte = 8'($urandom);
    rd_len = 2'($urandom);
    check("busy_c1", busy, 1);
    check("ack_err_clr", ack_err, 0);
    got_done = 0;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (rd_valid) got.push_back(rd_data);
      if (done) begin
        got_done = 1;
        check("done_cyc", cyc - c0, exp_cyc);
        check("ack_err", ack_err, nack);
        check("busy_end", busy, 0);
      end else begin
        start = t_spam && ($urandom_range(0, 9) == 0);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    repeat (3) @(negedge clk);
    stretch_slot = -1;
    check("done_pulses", n_done - d0, 1);
    check("starts", starts - st0, 1);
    check("stops", stops - sp0, 1);
    check("rd_count", got.size(), (nack || !t_rw) ? 0 : n);
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("rd_byte%0d", i), got[i], sdata[i]);
    // the STOP's own SCL rise is seen as one extra rise
    slots = nack ? 9 : (t_rw ? 9 + 9 * n : 18);
    check("scl_rises", rises, slots + 1);
    check("addr_byte", bus_byte(0), {t_addr, t_rw});
    check("addr_ack_bit", bus_bits[8], nack);
    if (!nack && !t_rw) begin
      check("wr_byte_bus", bus_byte(9), t_wr);
      check("wr_ack_bit", bus_bits[17], 0);
    end
    if (!nack && t_rw) begin
      for (int i = 0; i < n; i++) begin
        check($sformatf("rd_bus%0d", i), bus_byte(9 + 9 * i), sdata[i]);
        check($sformatf("m_ack%0d", i), bus_bits[17 + 9 * i], i == n - 1);
      end
    end
  endtask

  task automatic reset_mid_read();
    int k, d0, nv;
    for (int i = 0; i < 4; i++) sdata[i] = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    rw = 1'b1;
    addr = SLV;
    rd_len = 2'd3;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!rd_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rst_first_byte", rd_valid, 1);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_scl", scl_out, 1);
    check("rst_sda", sda_out, 1);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = n_done;
    nv = 0;
    repeat (400) begin
      @(negedge clk);
      if (rd_valid) nv++;
    end
    check("rst_no_done", n_done - d0, 0);
    check("rst_no_rdv", nv, 0);
  endtask

  initial begin
    logic [6:0] a;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scl_out", scl_out, 1);
    check("rst_sda_out", sda_out, 1);
    check("rst_busy0", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) sdata[i] = 8'($urandom);
    run_txn(1'b0, SLV, 8'hA5, 2'd0, 1'b0, 1'b0);

    sdata[0] = 8'hDE;
    sdata[1] = 8'hAD;
    sdata[2] = 8'hBE;
    sdata[3] = 8'hEF;
    run_txn(1'b1, SLV, 8'h00, 2'd3, 1'b0, 1'b0);

    run_txn(1'b0, 7'h11, 8'h3C, 2'd0, 1'b0, 1'b0);
    run_txn(1'b0, SLV, 8'hA5, 2'd0, 1'b1, 1'b0);

    reset_mid_read();
    sdata[0] = 8'h5C;
    sdata[1] = 8'h81;
    run_txn(1'b1, SLV, 8'h00, 2'd1, 1'b0, 1'b0);

    run_txn(1'b0, SLV, 8'h5A, 2'd0, 1'b0, 1'b1);
    run_txn(1'b1, SLV, 8'h00, 2'd2, 1'b0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 4; i++) sdata[i] = 8'($urandom);
      a = ($urandom_range(0, 9) < 7) ? SLV : 7'($urandom);
      run_txn(1'($urandom), a, 8'($urandom), 2'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
